// File: rtl/clk_div_defs_pkg.sv
// clk_div_defs: shared constants, types and helpers for the clock-divider bank.
//   DIV_W_DFLT   - default divisor width (max period 2^DIV_W-1 input cycles)
//   DEF_DIV_DFLT - default reset divisor (1 ms at 100 MHz)
//   CH_IDX_W     - width of the channel-index field on the write port
//   calc_neff    - effective divisor, max(N,1)
//   calc_hi      - high-phase length, ceil(Neff/2)
package clk_div_defs;

    localparam int DIV_W_DFLT   = 27;
    localparam int DEF_DIV_DFLT = 100000;
    localparam int CH_IDX_W     = 4;

    // Helpers work at a fixed 32-bit width so any DIV_W up to 32 can use them.
    localparam int CALC_W = 32;

    typedef enum logic {
        CH_IDLE,
        CH_RUN
    } ch_state_t;

    // A divisor of zero behaves like one: a tick every cycle.
    function automatic logic [CALC_W-1:0] calc_neff(input logic [CALC_W-1:0] n);
        return (n == '0) ? CALC_W'(1) : n;
    endfunction

    // High phase takes the extra cycle on odd divisors.
    function automatic logic [CALC_W-1:0] calc_hi(input logic [CALC_W-1:0] neff);
        return neff - (neff >> 1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel (counter, active divisor, shadow divisor,
// pending flag and registered outputs).
//   i_CLK, i_RST_N - clock, async active-low reset
//   i_EN           - run enable (level)
//   i_SYNC         - restart phase (enabled channels only)
//   i_WR, i_WR_DIV - divisor write strobe for this channel and new divisor
//   o_CLK, o_TICK  - divided square wave, one-cycle period-start strobe
//   o_PEND         - a written divisor waits for the next period boundary
module clk_div_chan
    import clk_div_defs::*;
#(
    parameter int DIV_W   = DIV_W_DFLT,
    parameter int DEF_DIV = DEF_DIV_DFLT
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_EN,
    input  logic             i_SYNC,
    input  logic             i_WR,
    input  logic [DIV_W-1:0] i_WR_DIV,
    output logic             o_CLK,
    output logic             o_TICK,
    output logic             o_PEND
);

    ch_state_t        state_reg,  state_next;
    logic [DIV_W-1:0] cnt_reg,    cnt_next;
    logic [DIV_W-1:0] div_reg,    div_next;
    logic [DIV_W-1:0] shadow_reg, shadow_next;
    logic             pend_reg,   pend_next;
    logic             clk_reg,    clk_next;
    logic             tick_reg,   tick_next;

    logic [DIV_W-1:0] neff;
    logic [DIV_W-1:0] hi;
    logic             wrap;
    logic [DIV_W-1:0] cnt_inc;

    assign neff    = DIV_W'(calc_neff(CALC_W'(div_reg)));
    assign hi      = DIV_W'(calc_hi(CALC_W'(neff)));
    assign wrap    = (cnt_reg == neff - DIV_W'(1));
    assign cnt_inc = wrap ? '0 : cnt_reg + DIV_W'(1);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_reg  <= CH_IDLE;
            cnt_reg    <= '0;
            div_reg    <= DIV_W'(DEF_DIV);
            shadow_reg <= DIV_W'(DEF_DIV);
            pend_reg   <= 1'b0;
            clk_reg    <= 1'b0;
            tick_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            div_reg    <= div_next;
            shadow_reg <= shadow_next;
            pend_reg   <= pend_next;
            clk_reg    <= clk_next;
            tick_reg   <= tick_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        div_next    = div_reg;
        shadow_next = shadow_reg;
        pend_next   = pend_reg;
        clk_next    = clk_reg;
        tick_next   = tick_reg;

        if (!i_EN) begin
            // Idle: outputs low; anything pending is committed, and new
            // writes take effect at once since there is no period to protect.
            state_next = CH_IDLE;
            cnt_next   = '0;
            clk_next   = 1'b0;
            tick_next  = 1'b0;
            pend_next  = 1'b0;
            if (pend_reg) begin
                div_next = shadow_reg;
            end
            if (i_WR) begin
                shadow_next = i_WR_DIV;
                div_next    = i_WR_DIV;
            end
        end else if (state_reg == CH_IDLE || i_SYNC) begin
            // Start of a fresh period. The commit uses the shadow as it was
            // before this edge, so a coincident write stays pending.
            state_next = CH_RUN;
            cnt_next   = '0;
            clk_next   = 1'b1;
            tick_next  = 1'b1;
            pend_next  = 1'b0;
            if (pend_reg) begin
                div_next = shadow_reg;
            end
            if (i_WR) begin
                shadow_next = i_WR_DIV;
                pend_next   = 1'b1;
            end
        end else begin
            cnt_next  = cnt_inc;
            tick_next = (cnt_inc == '0);
            clk_next  = (cnt_inc < hi);
            // Divisor swaps only at the wrap so no period is ever truncated.
            if (wrap && pend_reg) begin
                div_next  = shadow_reg;
                pend_next = 1'b0;
            end
            if (i_WR) begin
                shadow_next = i_WR_DIV;
                pend_next   = 1'b1;
            end
        end
    end

    assign o_CLK  = clk_reg;
    assign o_TICK = tick_reg;
    assign o_PEND = pend_reg;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH independent runtime-programmable clock dividers.
//   i_CLK, i_RST_N          - clock, async active-low reset
//   i_EN[NUM_CH]            - per-channel run enable
//   i_SYNC                  - restart phase of all enabled channels
//   i_WR, i_WR_CH, i_WR_DIV - divisor write (out-of-range channel ignored)
//   o_CLK, o_TICK, o_PEND   - per-channel square wave, tick strobe, pending flag
module clk_div_bank
    import clk_div_defs::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = DIV_W_DFLT,
    parameter int DEF_DIV = DEF_DIV_DFLT
) (
    input  logic                i_CLK,
    input  logic                i_RST_N,
    input  logic [NUM_CH-1:0]   i_EN,
    input  logic                i_SYNC,
    input  logic                i_WR,
    input  logic [CH_IDX_W-1:0] i_WR_CH,
    input  logic [DIV_W-1:0]    i_WR_DIV,
    output logic [NUM_CH-1:0]   o_CLK,
    output logic [NUM_CH-1:0]   o_TICK,
    output logic [NUM_CH-1:0]   o_PEND
);

    logic [NUM_CH-1:0] wr_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            // Indices at or above NUM_CH match no channel, so such writes drop.
            assign wr_en[gi] = i_WR && (i_WR_CH == CH_IDX_W'(gi));

            clk_div_chan #(
                .DIV_W   (DIV_W),
                .DEF_DIV (DEF_DIV)
            ) u_chan (
                .i_CLK    (i_CLK),
                .i_RST_N  (i_RST_N),
                .i_EN     (i_EN[gi]),
                .i_SYNC   (i_SYNC),
                .i_WR     (wr_en[gi]),
                .i_WR_DIV (i_WR_DIV),
                .o_CLK    (o_CLK[gi]),
                .o_TICK   (o_TICK[gi]),
                .o_PEND   (o_PEND[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed bench for clk_div_bank with DEF_DIV = 10.
module tb_clk_div_bank;

    localparam int NUM_CH  = 4;
    localparam int DIV_W   = 27;
    localparam int DEF_DIV = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NUM_CH-1:0] en = '0;
    logic              sync = 1'b0;
    logic              wr = 1'b0;
    logic [3:0]        wr_ch = '0;
    logic [DIV_W-1:0]  wr_div = '0;
    logic [NUM_CH-1:0] o_clk, o_tick, o_pend;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] t, c, p;

    clk_div_bank #(
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .i_CLK    (clk),
        .i_RST_N  (rst_n),
        .i_EN     (en),
        .i_SYNC   (sync),
        .i_WR     (wr),
        .i_WR_CH  (wr_ch),
        .i_WR_DIV (wr_div),
        .o_CLK    (o_clk),
        .o_TICK   (o_tick),
        .o_PEND   (o_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int ch, input int div);
        wr     = 1'b1;
        wr_ch  = 4'(ch);
        wr_div = DIV_W'(div);
    endtask

    // Record n cycles of one channel; bit i is the sample after the i-th edge.
    // Write and sync strobes are dropped after the first edge.
    task automatic capture(input int ch, input int n,
                           output logic [31:0] tv, output logic [31:0] cv,
                           output logic [31:0] pv);
        tv = '0; cv = '0; pv = '0;
        for (int i = 0; i < n; i++) begin
            step();
            wr   = 1'b0;
            sync = 1'b0;
            tv[i] = o_tick[ch];
            cv[i] = o_clk[ch];
            pv[i] = o_pend[ch];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        step(); step();
        check("rst_clk",  32'(o_clk),  32'h0);
        check("rst_tick", 32'(o_tick), 32'h0);
        check("rst_pend", 32'(o_pend), 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_clk", 32'(o_clk), 32'h0);

        // Default divisor 10 on channel 0, first tick one cycle after enable
        en = 4'b0001;
        capture(0, 20, t, c, p);
        check("def_tick", t, 32'h00401);
        check("def_clk",  c, 32'h07C1F);
        check("def_pend", p, 32'h0);

        // N=5 on disabled channel 1 applies immediately
        set_wr(1, 5); step(); wr = 1'b0;
        check("dis_wr_pend", 32'(o_pend), 32'h0);
        en = 4'b0011;
        capture(1, 10, t, c, p);
        check("n5_tick", t, 32'h21);
        check("n5_clk",  c, 32'hE7);

        // N=1
        en = 4'b0001; set_wr(1, 1); step(); wr = 1'b0; en = 4'b0011;
        capture(1, 8, t, c, p);
        check("n1_tick", t, 32'hFF);
        check("n1_clk",  c, 32'hFF);

        // N=2
        en = 4'b0001; set_wr(1, 2); step(); wr = 1'b0; en = 4'b0011;
        capture(1, 8, t, c, p);
        check("n2_tick", t, 32'h55);
        check("n2_clk",  c, 32'h55);

        // Channel 0 at N=10, write N=4 while cnt=3
        en = 4'b0010; step();
        en = 4'b0011; step();
        check("restart_tick0", 32'(o_tick[0]), 32'h1);
        step(); step(); step();
        set_wr(0, 4);
        capture(0, 16, t, c, p);
        check("chg_tick", t, 32'h4440);
        check("chg_clk",  c, 32'hCCC1);
        check("chg_pend", p, 32'h003F);

        // Four channels at 6..9, pending write, then sync
        en = 4'b0000; step();
        for (int k = 0; k < NUM_CH; k++) begin
            set_wr(k, 6 + k); step();
        end
        wr = 1'b0;
        en = 4'b1111; step();
        check("all_first_tick", 32'(o_tick), 32'hF);
        step(); step(); step();
        set_wr(2, 3); step(); wr = 1'b0;
        check("sync_pre_pend", 32'(o_pend), 32'h4);
        sync = 1'b1; step(); sync = 1'b0;
        check("sync_tick", 32'(o_tick), 32'hF);
        check("sync_clk",  32'(o_clk),  32'hF);
        check("sync_pend", 32'(o_pend), 32'h0);
        capture(2, 6, t, c, p);
        check("sync_n3_tick", t, 32'h24);
        check("sync_n3_clk",  c, 32'h2D);

        // Sync and write to the same channel in one cycle
        sync = 1'b1; set_wr(3, 2); step(); sync = 1'b0; wr = 1'b0;
        check("syncwr_pend", 32'(o_pend), 32'h8);
        check("syncwr_tick", 32'(o_tick), 32'hF);
        capture(3, 12, t, c, p);
        check("syncwr_tick3", t, 32'h500);
        check("syncwr_clk3",  c, 32'h50F);
        check("syncwr_pend3", p, 32'hFF);

        // Out-of-range channel index is ignored
        set_wr(5, 3); step(); wr = 1'b0;
        check("oor_pend", 32'(o_pend), 32'h0);
        capture(0, 12, t, c, p);
        check("oor_tick0", t, 32'h410);
        check("oor_clk0",  c, 32'hC71);
        check("oor_pend0", p, 32'h0);

        // Asynchronous reset between edges
        set_wr(0, 8); step(); wr = 1'b0;
        check("pre_rst_pend0", 32'(o_pend[0]), 32'h1);
        check("pre_rst_clk0",  32'(o_clk[0]),  32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("async_clk",  32'(o_clk),  32'h0);
        check("async_tick", 32'(o_tick), 32'h0);
        check("async_pend", 32'(o_pend), 32'h0);
        en = 4'b0001;
        step(); step();
        rst_n = 1'b1;
        capture(0, 20, t, c, p);
        check("post_rst_tick", t, 32'h00401);
        check("post_rst_clk",  c, 32'h07C1F);
        check("post_rst_pend", p, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel, runtime-programmable clock divider. Successor to the single fixed-ratio divider.
- Produces NUM_CH independent divided square waves plus single-cycle tick strobes from one system clock.
- Each channel has its own divisor, written at runtime, with glitch-free divisor changes at period boundaries.
- Sits between the 100 MHz board clock and timers, display scanners and debouncers, which consume the o_TICK strobes as clock enables.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- DIV_W, 27, divisor width in bits; maximum period 2^DIV_W-1 input cycles.
- DEF_DIV, 100000, reset divisor of every channel (1 ms period at 100 MHz).

Ports:
- i_CLK  in  1  system clock; all state updates on rising edge.
- i_RST_N  in  1  reset, asynchronous assert, active-low; releases on the next i_CLK edge after deassertion.
- i_EN  in  NUM_CH  per-channel run enable, level-sensitive.
- i_SYNC  in  1  one-cycle pulse; restarts the phase of all enabled channels together.
- i_WR  in  1  divisor write strobe.
- i_WR_CH  in  4  target channel index for the write.
- i_WR_DIV  in  DIV_W  new divisor N (period in i_CLK cycles).
- o_CLK  out  NUM_CH  divided square wave per channel.
- o_TICK  out  NUM_CH  one-cycle strobe at the start of each period.
- o_PEND  out  NUM_CH  a written divisor is waiting to be applied.

Behaviour:
- Reset (i_RST_N low, async):
  - every channel: cnt=0, div=DEF_DIV, shadow=DEF_DIV, pend=0
  - o_CLK=0, o_TICK=0, o_PEND=0
- Effective divisor: Neff = max(N,1). High phase HI = Neff - floor(Neff/2), i.e. ceil(Neff/2).
- All outputs are registered. There is no combinational path from any input to any output.
- Channel disabled (i_EN[k]=0): on each edge cnt<=0, o_CLK[k]<=0, o_TICK[k]<=0.
- Channel enabled, first cycle (i_EN[k] sampled 1 after being 0): cnt<=0, o_TICK[k]<=1, o_CLK[k]<=1. The first tick is visible one cycle after enable is sampled.
- Channel running:
  - cnt_n = (cnt==Neff-1) ? 0 : cnt+1
  - cnt<=cnt_n
  - o_TICK[k]<=(cnt_n==0)
  - o_CLK[k]<=(cnt_n<HI)
  - Result: period Neff cycles, o_CLK high for HI cycles, o_TICK high exactly one cycle per period, coincident with the o_CLK rising cycle.
- N=1 (or 0): o_TICK high every cycle; o_CLK stays high. No toggling at the input rate.
- N=2: o_CLK toggles every cycle; o_TICK high every other cycle.
- Divisor write (i_WR=1, i_WR_CH<NUM_CH):
  - shadow[ch]<=i_WR_DIV and pend[ch]<=1.
  - If the channel is disabled, div<=i_WR_DIV immediately and pend stays 0.
- Pending divisor, running channel: applied on the edge where cnt wraps to 0 (cnt==Neff-1). The new period starts with that tick. pend clears on the same edge.
- Write on the exact wrap edge: the new value is not applied on that edge. It waits for the next wrap.
- Repeated writes before a wrap: the last write wins.
- i_WR_CH>=NUM_CH: the write is ignored and no state changes.
- i_SYNC=1: every enabled channel behaves as if on its first cycle: cnt<=0, o_TICK<=1, o_CLK<=1, and any pending divisor is applied (pend<=0).
  - Disabled channels ignore i_SYNC.
  - i_SYNC and i_WR to the same channel in the same cycle: the sync commits the old shadow; the write lands in shadow with pend=1.
- i_EN dropped mid-period: the channel returns to the disabled state next edge. The pending divisor is committed to div.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Decomposition:
- Shared header/package clk_div_defs holds:
  - default parameter constants (DEF_DIV, DIV_W)
  - the channel-index width
  - the Neff and HI computation as a function
- Sub-module clk_div_chan contains one channel: cnt, div, shadow, pend and output registers.
- clk_div_bank generates NUM_CH instances and decodes i_WR_CH into per-channel write enables.

Test Plan:
- Reset, then i_EN[0]=1 with DEF_DIV overridden to 10 -> o_TICK[0] pulses every 10 cycles; o_CLK[0] high 5, low 5; first tick 1 cycle after enable.
- Odd divisor N=5 on channel 1 -> o_CLK[1] high 3 cycles, low 2; o_TICK[1] period 5; N=1 -> o_TICK constant high, o_CLK constant high; N=2 -> o_CLK toggles each cycle.
- Channel 0 running at N=10, write N=4 at cnt=3:
  - o_PEND[0]=1 until the wrap, and the current period completes at 10 cycles.
  - Then periods of 4 follow, and o_PEND[0] clears on the wrap edge.
- Channels 0..3 at N=6,7,8,9, all enabled, then i_SYNC pulse -> all o_TICK assert together the next cycle; pending writes are committed.
- Write to i_WR_CH=5 with NUM_CH=4 -> no change in any o_PEND, divisor or output waveform.
- Assert i_RST_N low asynchronously mid-period (between clock edges) -> o_CLK, o_TICK and o_PEND drop to 0 without waiting for an edge; after release, divisors equal DEF_DIV.
